// File: rtl/gradients_ctrl_if.sv
// Handshake and window-position bundle between the gradients controller and its neighbours.
interface gradients_ctrl_if;
    localparam int unsigned CW = 12;

    logic          frame_start;
    logic          pix_valid;
    logic          pix_ready;
    logic          lb_shift;
    logic          grad_start;
    logic [CW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic          res_valid;
    logic          res_ready;
    logic          busy;
    logic          frame_done;

    // Controller side
    modport slave (
        input  frame_start, pix_valid, res_ready,
        output pix_ready, lb_shift, grad_start, win_row, win_col,
               res_valid, busy, frame_done
    );

    // Source/sink side
    modport master (
        output frame_start, pix_valid, res_ready,
        input  pix_ready, lb_shift, grad_start, win_row, win_col,
               res_valid, busy, frame_done
    );
endinterface

// File: rtl/gradients_ctrl.sv
// Raster-scan controller for a 5x5 gradients window: accepts pixels, issues one
// window at a time to the gradients datapath, and holds results until consumed.
module gradients_ctrl #(
    parameter int unsigned IMG_W    = 64,
    parameter int unsigned IMG_H    = 64,
    parameter int unsigned GRAD_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    gradients_ctrl_if.slave  bus
);
    localparam int unsigned CW = 12;
    localparam int unsigned LW = 4;

    localparam logic [CW-1:0] COL_LAST     = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_LAST     = CW'(IMG_H - 1);
    localparam logic [CW-1:0] WIN_COL_LAST = CW'(IMG_W - 3);
    localparam logic [CW-1:0] WIN_ROW_LAST = CW'(IMG_H - 3);
    localparam logic [CW-1:0] WIN_EDGE     = CW'(4);
    localparam logic [CW-1:0] WIN_OFS      = CW'(2);
    localparam logic [LW-1:0] LAT_END      = LW'(GRAD_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [CW-1:0] win_row_q, win_row_d;
    logic [CW-1:0] win_col_q, win_col_d;
    logic          grad_start_q, grad_start_d;
    logic          pix_ready_q, pix_ready_d;
    logic          res_valid_q, res_valid_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;

    logic          accept_c;
    logic          win_hit_c;
    logic          last_win_c;

    // A pixel moves only while the registered ready is high
    assign accept_c   = pix_ready_q & bus.pix_valid;
    assign win_hit_c  = accept_c && (row_q >= WIN_EDGE) && (col_q >= WIN_EDGE);
    assign last_win_c = (win_row_q == WIN_ROW_LAST) && (win_col_q == WIN_COL_LAST);

    // Next-state, counter and registered-output decode
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        lat_d        = lat_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        grad_start_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.frame_start) begin
                    state_d = S_RUN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_RUN: begin
                if (accept_c) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : CW'(row_q + CW'(1));
                    end else begin
                        col_d = CW'(col_q + CW'(1));
                    end
                end
                if (win_hit_c) begin
                    grad_start_d = 1'b1;
                    win_row_d    = CW'(row_q - WIN_OFS);
                    win_col_d    = CW'(col_q - WIN_OFS);
                    lat_d        = LW'(1);
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                // lat_q equals the number of cycles elapsed since grad_start, inclusive
                if (lat_q >= LAT_END) begin
                    state_d = S_HOLD;
                end else begin
                    lat_d = LW'(lat_q + LW'(1));
                end
            end
            S_HOLD: begin
                if (bus.res_ready) begin
                    state_d = last_win_c ? S_DONE : S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        pix_ready_d  = (state_d == S_RUN);
        res_valid_d  = (state_d == S_HOLD);
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            lat_q        <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            grad_start_q <= 1'b0;
            pix_ready_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            lat_q        <= lat_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            grad_start_q <= grad_start_d;
            pix_ready_q  <= pix_ready_d;
            res_valid_q  <= res_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.pix_ready  = pix_ready_q;
    assign bus.lb_shift   = accept_c;
    assign bus.grad_start = grad_start_q;
    assign bus.win_row    = win_row_q;
    assign bus.win_col    = win_col_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: doc/gradients_ctrl.md
GRADIENTS_CTRL -- requirements
Module: gradients_ctrl

Interface
REQ-001 Parameter IMG_W, default 64: image width in pixels; legal range 5..4095.
REQ-002 Parameter IMG_H, default 64: image height in pixels; legal range 5..4095.
REQ-003 Parameter GRAD_LAT, default 3: cycles from grad_start to gradient outputs being valid; legal range 1..15.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 frame_start  input  1  one-cycle pulse that begins a frame.
REQ-007 pix_valid  input  1  raster pixel available upstream.
REQ-008 pix_ready  output  1  controller accepts a pixel this cycle.
REQ-009 lb_shift  output  1  line-buffer/window shift enable; equals pix_valid AND pix_ready.
REQ-010 grad_start  output  1  start pulse to the gradients datapath.
REQ-011 win_row  output  12  window-centre row of the current/last issued window.
REQ-012 win_col  output  12  window-centre column of the current/last issued window.
REQ-013 res_valid  output  1  gradient results valid for downstream.
REQ-014 res_ready  input  1  downstream consumes the result.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-017 States: IDLE, RUN, WAIT, HOLD, DONE; encoding is free.
REQ-018 IDLE: pix_ready=0; frame_start=1 -> RUN, with row and column counters cleared to 0.
REQ-019 RUN: pix_ready=1; each accepted pixel is at (row,col) and advances col; col=IMG_W-1 wraps col to 0 and increments row.
REQ-020 RUN, accepted pixel with row>=4 and col>=4: next cycle grad_start=1 for exactly one cycle, win_row=row-2, win_col=col-2, state -> WAIT.
REQ-021 RUN, accepted pixel with row<4 or col<4: no grad_start; state remains RUN.
REQ-022 WAIT: pix_ready=0; a latency counter runs GRAD_LAT cycles counted from the grad_start cycle; res_valid rises exactly GRAD_LAT cycles after grad_start, state -> HOLD.
REQ-023 HOLD: pix_ready=0; res_valid stays 1 and win_row/win_col stay stable until res_ready=1.
REQ-024 HOLD with res_ready=1: res_valid drops next cycle; if the consumed window was the last of the frame (centre IMG_H-3, IMG_W-3), state -> DONE, otherwise -> RUN.
REQ-025 DONE: frame_done=1 for one cycle, then IDLE; win_row/win_col hold their last values.
REQ-026 frame_start outside IDLE is ignored.
REQ-027 pix_valid=0 in RUN: counters hold; no output change.
REQ-028 Windows per frame = (IMG_W-4)*(IMG_H-4) grad_start pulses, issued in raster order.
REQ-029 grad_start and res_valid are never high in the same cycle, because at most one window is in flight.
REQ-030 Counters are 12-bit unsigned; no wrap beyond IMG_W-1 or IMG_H-1 within a frame.

Reset
REQ-031 rst=0 sampled at a clock edge -> state IDLE, counters 0, and all outputs 0 (pix_ready, lb_shift, grad_start, win_row, win_col, res_valid, busy, frame_done) on the following cycle.
REQ-032 Reset asserted mid-frame (any state) aborts the frame: no further grad_start, res_valid or frame_done until a new frame_start.
REQ-033 Reset has priority over frame_start and over every handshake.

Verification (IMG_W=8, IMG_H=6, GRAD_LAT=3)
REQ-034 Reset, then frame_start with pix_valid held 1 and res_ready held 1 -> exactly 8 grad_start pulses with (win_row,win_col) = (2,2),(2,3),(2,4),(2,5),(3,2)..(3,5); frame_done pulses once; busy returns 0.
REQ-035 First window: pixel (4,4) accepted at cycle t -> grad_start at t+1, res_valid at t+4, pix_ready=0 from t+1 through the HOLD exit.
REQ-036 res_ready held 0 for 10 cycles in HOLD -> res_valid stays 1, win_row/win_col are unchanged, pix_ready=0, lb_shift=0; release -> RUN on the next cycle.
REQ-037 pix_valid toggled 1/0 every cycle -> same 8 windows in the same order; lb_shift pulses total 48.
REQ-038 rst=0 in WAIT after the third window -> all outputs 0 next cycle; no res_valid; a new frame_start restarts at (0,0) and produces 8 windows.
REQ-039 frame_start pulsed during RUN and HOLD -> ignored; window count remains 8.
